button_action_gen: RTL and testbench
====================================

// Module: button_action_gen
// PURPOSE
//  Converts debounced, level-valued button signals into single-cycle game-action pulses.
//  Shift and soft-drop channels auto-repeat: one pulse on press, one after DAS_CYCLES,
//  then one every ARR_CYCLES while held. Rotate and hard-drop fire once per press.
//  Sits between the per-button debounce stages and the tetris game-logic FSM.
// PARAMETERS
//  NUM_BTN      5            channels; bit0=left, 1=right, 2=down, 3=rotate, 4=hard drop
//  REPEAT_MASK  5'b00111     1 = channel auto-repeats, 0 = one pulse per press
//  DAS_CYCLES   12_375_000   cycles from initial pulse to first repeat (~167 ms @ 74.25 MHz)
//  ARR_CYCLES   3_712_500    cycles between subsequent repeats (~50 ms @ 74.25 MHz)
// PORTS
//  clk_in     in   1        system clock, single domain
//  reset_in   in   1        synchronous, active-high reset
//  btn_in     in   NUM_BTN  debounced button levels, active-high
//  enable_in  in   1        1 = game accepting input; 0 = mask and re-arm all channels
//  pulse_out  out  NUM_BTN  one-cycle action pulses, registered
//  held_out   out  NUM_BTN  registered copy of effective (post-conflict) levels
// BEHAVIOUR
//  - Reset: pulse_out=0, held_out=0, all channels IDLE, counters=0.
//    Edge register loads the current effective level, so a button held through reset
//    produces no pulse until released and re-pressed.
//  - Conflict rule: eff[0]=btn_in[0]&~btn_in[1], eff[1]=btn_in[1]&~btn_in[0];
//    eff[k]=btn_in[k] for k>=2. With left and right both held, neither channel fires.
//    Releasing one makes the other's eff rise, which counts as a fresh press.
//  - Latency: eff rises at cycle N (low at N-1) -> pulse_out[k]=1 at N+1, exactly 1 cycle.
//  - Per-channel FSM, state and counter updated every clk_in edge:
//    IDLE:   on eff rising -> initial pulse; counter=0; go DELAY if REPEAT_MASK[k],
//            else go HOLD.
//    DELAY:  counter increments while eff=1. When the counter reaches DAS_CYCLES-1:
//            pulse, counter=0, go REPEAT. First repeat pulse is exactly DAS_CYCLES
//            cycles after the initial pulse.
//    REPEAT: when the counter reaches ARR_CYCLES-1: pulse, counter=0. Repeat spacing is
//            exactly ARR_CYCLES cycles.
//    HOLD:   no pulses. Stays until eff=0.
//    Any state: eff=0 -> IDLE next cycle, counter=0, no release pulse.
//  - Re-press on the cycle immediately after a release is a valid new press (IDLE
//    rising edge).
//  - enable_in=0: pulse_out forced to 0 the same cycle, all channels -> IDLE, counters=0,
//    edge register tracks eff. Buttons already held when enable_in rises do not fire.
//    enable_in does not gate held_out.
//  - Channels are independent. Simultaneous presses on different channels pulse in the
//    same cycle.
//  - Counters are $clog2(max(DAS_CYCLES,ARR_CYCLES)) bits, unsigned. They reset on every
//    transition and never wrap.
//  - Parameter legality: DAS_CYCLES>=2 and ARR_CYCLES>=2, checked by elaboration
//    assertion.
//  - reset_in mid-DELAY/REPEAT: next cycle matches the reset state above, with no pulse.
// TESTING  (bench uses DAS_CYCLES=10, ARR_CYCLES=4)
//  - Press btn_in[3] at cycle 5, hold 100 cycles -> pulse_out[3] only at cycle 6;
//    held_out[3]=1 from cycle 6.
//  - Press btn_in[0] at cycle 5, hold -> pulse_out[0] at cycles 6, 16, 20, 24, ...
//    Release at cycle 22 -> no further pulses.
//  - Hold btn_in[0] from cycle 5; assert btn_in[1] at 8; release btn_in[1] at 30 ->
//    pulse_out[0] at 6 only until 31, then pulses at 31, 41, 45, ...; pulse_out[1] never.
//  - btn_in[2] high during reset_in, reset released at cycle 3 -> no pulse. Release at 20,
//    re-press at 21 -> pulse at 22.
//  - enable_in=0 while btn_in[4] rises at 5 -> no pulse. enable_in=1 at 9 with button held
//    -> no pulse. Release then press -> one pulse.
//  - reset_in for 1 cycle at cycle 18 during btn_in[0] REPEAT -> no pulses until the
//    button is released and re-pressed.

Source files
------------

// File: rtl/button_action_gen.sv
// -----------------------------------------------------------------------------
// button_action_gen
//
// Purpose
//   Turns debounced, level-valued button signals into single-cycle game-action
//   pulses for the game-logic FSM. Channels flagged in REPEAT_MASK auto-repeat:
//     - one pulse on press,
//     - one pulse DAS_CYCLES later,
//     - then one pulse every ARR_CYCLES while the button stays held.
//   All other channels fire exactly once per press.
//   Left and right cancel each other while both are held.
//
// Ports
//   clk_in     in   1            system clock, single domain
//   reset_in   in   1            synchronous, active-high reset
//   btn_in     in   NUM_BTN      debounced button levels, active-high
//                                (bit0 left, 1 right, 2 down, 3 rotate, 4 hard drop)
//   enable_in  in   1            1 = accept input; 0 = mask pulses, re-arm all channels
//   pulse_out  out  NUM_BTN      one-cycle action pulses
//   held_out   out  NUM_BTN      registered effective (post-conflict) levels
//   state_dbg  out  2*NUM_BTN    per-channel FSM state, channel k at [2k+1:2k]
//                                (00 idle, 01 delay, 10 repeat, 11 hold)
// -----------------------------------------------------------------------------
module button_action_gen #(
  parameter int                 NUM_BTN     = 5,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = 5'b00111,
  parameter int                 DAS_CYCLES  = 12_375_000,
  parameter int                 ARR_CYCLES  = 3_712_500
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [NUM_BTN-1:0]     btn_in,
  input  logic                   enable_in,
  output logic [NUM_BTN-1:0]     pulse_out,
  output logic [NUM_BTN-1:0]     held_out,
  output logic [2*NUM_BTN-1:0]   state_dbg
);

  // ---------------------------------------------------------------------------
  // Parameter legality. A delay or repeat period below two cycles would make
  // the "counter reaches N-1" test fire on the very first held cycle and break
  // the pulse spacing guarantees. The conflict rule needs both left and right.
  // ---------------------------------------------------------------------------
  if (DAS_CYCLES < 2 || ARR_CYCLES < 2) begin : g_bad_timing
    $error("button_action_gen: DAS_CYCLES and ARR_CYCLES must both be >= 2");
  end
  if (NUM_BTN < 2) begin : g_bad_width
    $error("button_action_gen: NUM_BTN must be >= 2 (left/right channels)");
  end

  // ---------------------------------------------------------------------------
  // Counter sizing: wide enough for the larger of the two periods.
  // ---------------------------------------------------------------------------
  localparam int MAX_CYCLES = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] DAS_LAST = CW'(DAS_CYCLES - 1);
  localparam logic [CW-1:0] ARR_LAST = CW'(ARR_CYCLES - 1);

  // Per-channel FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // ---------------------------------------------------------------------------
  // Effective levels after the left/right conflict rule. Holding both makes
  // both channels look released; letting go of one makes the other rise,
  // which the edge detector then treats as a fresh press.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] eff;

  always_comb begin
    eff    = btn_in;
    eff[0] = btn_in[0] & ~btn_in[1];
    eff[1] = btn_in[1] & ~btn_in[0];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] prev_eff_q;   // edge register
  logic [NUM_BTN-1:0] pulse_q;
  logic [NUM_BTN-1:0] held_q;
  logic [1:0]         state_q [NUM_BTN];
  logic [CW-1:0]      cnt_q   [NUM_BTN];

  logic [NUM_BTN-1:0] pulse_d;
  logic [1:0]         state_d [NUM_BTN];
  logic [CW-1:0]      cnt_d   [NUM_BTN];

  logic [NUM_BTN-1:0] rise;

  // A press is a rising effective level seen by the edge register. The edge
  // register tracks eff unconditionally (through reset and while disabled),
  // so a button already down when the block wakes up never counts as a press.
  assign rise = eff & ~prev_eff_q;

  // ---------------------------------------------------------------------------
  // Per-channel next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pulse_d = '0;
    state_d = state_q;
    cnt_d   = cnt_q;

    for (int k = 0; k < NUM_BTN; k++) begin
      if (!enable_in || !eff[k]) begin
        // Release (or masking) from any state re-arms the channel silently.
        state_d[k] = ST_IDLE;
        cnt_d[k]   = '0;
      end else begin
        case (state_q[k])
          ST_IDLE: begin
            if (rise[k]) begin
              pulse_d[k] = 1'b1;
              cnt_d[k]   = '0;
              state_d[k] = REPEAT_MASK[k] ? ST_DELAY : ST_HOLD;
            end
          end

          ST_DELAY: begin
            // Counter sits at 0 on the cycle after the initial pulse is
            // registered, so reaching DAS_LAST lands the first repeat
            // exactly DAS_CYCLES cycles after the initial pulse.
            if (cnt_q[k] == DAS_LAST) begin
              pulse_d[k] = 1'b1;
              cnt_d[k]   = '0;
              state_d[k] = ST_REPEAT;
            end else begin
              cnt_d[k]   = cnt_q[k] + 1'b1;
            end
          end

          ST_REPEAT: begin
            if (cnt_q[k] == ARR_LAST) begin
              pulse_d[k] = 1'b1;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k]   = cnt_q[k] + 1'b1;
            end
          end

          default: begin
            // ST_HOLD: one-shot channel already fired; wait for release.
            state_d[k] = ST_HOLD;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    prev_eff_q <= eff;
    if (reset_in) begin
      pulse_q <= '0;
      held_q  <= '0;
      for (int k = 0; k < NUM_BTN; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      pulse_q <= pulse_d;
      held_q  <= eff;
      for (int k = 0; k < NUM_BTN; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Dropping enable_in silences pulses in the same cycle; the
  // registered pulse is otherwise presented unchanged. held_out is not gated.
  // ---------------------------------------------------------------------------
  assign pulse_out = pulse_q & {NUM_BTN{enable_in}};
  assign held_out  = held_q;

  always_comb begin
    state_dbg = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      state_dbg[2*k +: 2] = state_q[k];
    end
  end

endmodule

// File: tb/tb_button_action_gen.sv
// -----------------------------------------------------------------------------
// tb_button_action_gen
//
// Self-checking bench for button_action_gen (DAS_CYCLES=10, ARR_CYCLES=4).
// A press-time reference model predicts pulse_out/held_out each cycle; the
// expectations go through a scoreboard queue and are compared after every
// clock edge. Directed scenarios add pulse-count checks, followed by a long
// randomized phase.
// -----------------------------------------------------------------------------
module tb_button_action_gen;

  localparam int              NB    = 5;
  localparam int              DAS   = 10;
  localparam int              ARR   = 4;
  localparam logic [NB-1:0]   RMASK = 5'b00111;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clk_in = 1'b0;
  logic            reset_in;
  logic            enable_in;
  logic [NB-1:0]   btn_in;
  logic [NB-1:0]   pulse_out;
  logic [NB-1:0]   held_out;
  logic [2*NB-1:0] state_dbg;

  always #5 clk_in = ~clk_in;

  button_action_gen #(
    .NUM_BTN     (NB),
    .REPEAT_MASK (RMASK),
    .DAS_CYCLES  (DAS),
    .ARR_CYCLES  (ARR)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .btn_in    (btn_in),
    .enable_in (enable_in),
    .pulse_out (pulse_out),
    .held_out  (held_out),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int               n_checks = 0;
  int               n_pass   = 0;
  int               cyc      = 0;
  logic [2*NB-1:0]  exp_q[$];       // {held, pulse} predicted per cycle
  int               press_cyc[NB];  // cycle of the current press, -1 if none
  logic [NB-1:0]    prev_eff_m;
  int               pcnt[NB];       // DUT pulses seen per channel

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a channel is "pressed since cycle P" while its effective
  // level has stayed high, the block is enabled and out of reset, and the
  // rise at P was a genuine low->high transition. Pulses are then due at
  // P, and for repeating channels at P+DAS+n*ARR, each visible one cycle later.
  // ---------------------------------------------------------------------------
  task automatic model_cycle();
    logic [NB-1:0] eff_m;
    logic [NB-1:0] pulse_m;
    logic [NB-1:0] held_m;
    int            age;
    eff_m    = btn_in;
    eff_m[0] = btn_in[0] && !btn_in[1];
    eff_m[1] = btn_in[1] && !btn_in[0];
    pulse_m  = '0;
    for (int k = 0; k < NB; k++) begin
      if (reset_in || !enable_in || !eff_m[k]) press_cyc[k] = -1;
      else if (!prev_eff_m[k])                  press_cyc[k] = cyc;
      if (press_cyc[k] >= 0) begin
        age = cyc - press_cyc[k];
        if (age == 0) pulse_m[k] = 1'b1;
        else if (RMASK[k] && age >= DAS && ((age - DAS) % ARR) == 0)
          pulse_m[k] = 1'b1;
      end
    end
    prev_eff_m = eff_m;
    held_m     = reset_in ? '0 : eff_m;
    exp_q.push_back({held_m, pulse_m});
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, then check the post-edge outputs.
  // ---------------------------------------------------------------------------
  task automatic step(input logic [NB-1:0] b, input logic en, input logic rst);
    logic [2*NB-1:0] e;
    btn_in    = b;
    enable_in = en;
    reset_in  = rst;
    model_cycle();
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check_eq("pulse", 32'(pulse_out), 32'(e[NB-1:0] & {NB{en}}));
    check_eq("held",  32'(held_out),  32'(e[2*NB-1:NB]));
    for (int k = 0; k < NB; k++) pcnt[k] += int'(pulse_out[k]);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic run(input logic [NB-1:0] b, input logic en, input logic rst,
                     input int n);
    for (int i = 0; i < n; i++) step(b, en, rst);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NB; k++) pcnt[k] = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [NB-1:0] rb;
    logic          ren;
    logic          rrst;

    btn_in     = '0;
    enable_in  = 1'b1;
    reset_in   = 1'b1;
    prev_eff_m = '0;
    for (int k = 0; k < NB; k++) press_cyc[k] = -1;
    clear_counts();
    @(negedge clk_in);

    // Reset state
    run(5'b00000, 1'b1, 1'b1, 3);
    check_eq("rst_pulse", 32'(pulse_out), 32'd0);
    check_eq("rst_held",  32'(held_out),  32'd0);
    run(5'b00000, 1'b1, 1'b0, 3);

    // Rotate: one pulse for a long hold
    clear_counts();
    run(5'b01000, 1'b1, 1'b0, 100);
    run(5'b00000, 1'b1, 1'b0, 4);
    check_eq("rot_cnt",   32'(pcnt[3]), 32'd1);
    check_eq("rot_other", 32'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[4]), 32'd0);

    // Left held 17 cycles: initial, +10, +14 -> 3 pulses
    clear_counts();
    run(5'b00001, 1'b1, 1'b0, 17);
    run(5'b00000, 1'b1, 1'b0, 10);
    check_eq("left_cnt", 32'(pcnt[0]), 32'd3);

    // Left/right conflict: 1 pulse, cancelled, then fresh press held 20 -> 4
    clear_counts();
    run(5'b00001, 1'b1, 1'b0, 3);
    run(5'b00011, 1'b1, 1'b0, 22);
    check_eq("conf_mid", 32'(pcnt[0]), 32'd1);
    run(5'b00001, 1'b1, 1'b0, 20);
    run(5'b00000, 1'b1, 1'b0, 3);
    check_eq("conf_left",  32'(pcnt[0]), 32'd5);
    check_eq("conf_right", 32'(pcnt[1]), 32'd0);

    // Down held through reset: no pulse; release and immediate re-press fires
    clear_counts();
    run(5'b00100, 1'b1, 1'b1, 3);
    run(5'b00100, 1'b1, 1'b0, 17);
    check_eq("rsthold_none", 32'(pcnt[2]), 32'd0);
    run(5'b00000, 1'b1, 1'b0, 1);
    run(5'b00100, 1'b1, 1'b0, 5);
    check_eq("rsthold_repress", 32'(pcnt[2]), 32'd1);
    run(5'b00000, 1'b1, 1'b0, 3);

    // Hard drop pressed while disabled, still held at enable: no pulse
    clear_counts();
    run(5'b10000, 1'b0, 1'b0, 4);
    run(5'b10000, 1'b1, 1'b0, 5);
    check_eq("en_none", 32'(pcnt[4]), 32'd0);
    run(5'b00000, 1'b1, 1'b0, 2);
    run(5'b10000, 1'b1, 1'b0, 3);
    check_eq("en_press", 32'(pcnt[4]), 32'd1);
    run(5'b00000, 1'b1, 1'b0, 3);

    // Reset pulse during left REPEAT: silent until re-press
    run(5'b00001, 1'b1, 1'b0, DAS + ARR + 2);
    clear_counts();
    run(5'b00001, 1'b1, 1'b1, 1);
    run(5'b00001, 1'b1, 1'b0, 30);
    check_eq("rep_rst_none", 32'(pcnt[0]), 32'd0);
    run(5'b00000, 1'b1, 1'b0, 2);
    run(5'b00001, 1'b1, 1'b0, 2);
    check_eq("rep_rst_repress", 32'(pcnt[0]), 32'd1);
    run(5'b00000, 1'b1, 1'b0, 3);

    // Randomized phase: slow button toggles, occasional disable and reset
    rb  = '0;
    ren = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NB; k++)
        if ($urandom_range(0, 15) == 0) rb[k] = ~rb[k];
      if ($urandom_range(0, 63) == 0) ren = ~ren;
      rrst = ($urandom_range(0, 199) == 0);
      step(rb, ren, rrst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle %0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
